// File: rtl/reflet_float_sequencer_pkg.sv
// Shared definitions for the float command sequencer: FPU opcodes, FSM states,
// result classes and the stall limit used by the optional timeout.
package reflet_float_sequencer_pkg;

   localparam logic [5:0] OPP_NOP       = 6'd0;
   localparam logic [5:0] OPP_ADD       = 6'd1;
   localparam logic [5:0] OPP_SUB       = 6'd2;
   localparam logic [5:0] OPP_MUL       = 6'd3;
   localparam logic [5:0] OPP_DIV       = 6'd4;
   localparam logic [5:0] OPP_INV       = 6'd5;
   localparam logic [5:0] OPP_FISQRT    = 6'd6;
   localparam logic [5:0] OPP_CUBE      = 6'd7;
   localparam logic [5:0] OPP_TESSERACT = 6'd8;
   localparam logic [5:0] OPP_TRIMULT   = 6'd9;
   localparam logic [5:0] OPP_MULTADD   = 6'd10;
   localparam logic [5:0] OPP_SET_SIGN  = 6'd11;
   localparam logic [5:0] OPP_I_TO_F    = 6'd12;
   localparam logic [5:0] OPP_F_TO_I    = 6'd13;
   localparam logic [5:0] OPP_CMP       = 6'd14;

   // Counter value seen during the 255th consecutive stalled EXEC cycle.
   localparam logic [7:0] SEQ_TIMEOUT_LAST = 8'd254;

   typedef enum logic [1:0] {
      REFLET_SEQ_IDLE = 2'd0,
      REFLET_SEQ_EXEC = 2'd1,
      REFLET_SEQ_WB   = 2'd2,
      REFLET_SEQ_DONE = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_FLOAT = 2'd1,
      RES_INT   = 2'd2,
      RES_CMP   = 2'd3
   } res_class_e;

   function automatic res_class_e op_class(input logic [5:0] op);
      res_class_e cls;
      case (op)
         OPP_ADD, OPP_SUB, OPP_MUL, OPP_DIV, OPP_INV, OPP_FISQRT, OPP_CUBE,
         OPP_TESSERACT, OPP_TRIMULT, OPP_MULTADD, OPP_SET_SIGN, OPP_I_TO_F:
            cls = RES_FLOAT;
         OPP_F_TO_I: cls = RES_INT;
         OPP_CMP:    cls = RES_CMP;
         default:    cls = RES_NONE;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/reflet_float_sequencer_regfile.sv
// Float register bank: one synchronous write port fed by the writeback path
// (priority) and the CPU path, three operand read ports and one CPU read port.
module reflet_float_regfile
   import reflet_float_sequencer_pkg::*;
#(
   parameter int float_size = 32,
   parameter int reg_count  = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wb_we_i,
   input  logic [$clog2(reg_count)-1:0]  wb_addr_i,
   input  logic [float_size-1:0]         wb_data_i,
   input  logic                          ext_we_i,
   input  logic [$clog2(reg_count)-1:0]  ext_addr_i,
   input  logic [float_size-1:0]         ext_data_i,
   input  logic [$clog2(reg_count)-1:0]  rd_addr1_i,
   input  logic [$clog2(reg_count)-1:0]  rd_addr2_i,
   input  logic [$clog2(reg_count)-1:0]  rd_addr3_i,
   input  logic [$clog2(reg_count)-1:0]  ext_raddr_i,
   output logic [float_size-1:0]         rd_data1_o,
   output logic [float_size-1:0]         rd_data2_o,
   output logic [float_size-1:0]         rd_data3_o,
   output logic [float_size-1:0]         ext_rdata_o
);

   logic [float_size-1:0] regs_q [reg_count];

   // NOTE: the bank is small and software expects it zeroed after reset, so the
   // memory is reset explicitly; larger RAM-style banks would not be.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < reg_count; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking updates; the later statement wins on the same
         // address, which gives the writeback priority over the CPU write.
         if (ext_we_i) regs_q[ext_addr_i] <= ext_data_i;
         if (wb_we_i)  regs_q[wb_addr_i]  <= wb_data_i;
      end
   end

   assign rd_data1_o  = regs_q[rd_addr1_i];
   assign rd_data2_o  = regs_q[rd_addr2_i];
   assign rd_data3_o  = regs_q[rd_addr3_i];
   assign ext_rdata_o = regs_q[ext_raddr_i];

endmodule

// File: rtl/reflet_float_sequencer.sv
// FPU command sequencer: snapshots operands, drives the arithmetic unit and
// retires results. Define REFLET_FPU_SEQ_TIMEOUT_EN for the EXEC stall timeout.
module reflet_float_sequencer
   import reflet_float_sequencer_pkg::*;
#(
   parameter int float_size   = 32,
   parameter int integer_size = 16,
   parameter int reg_count    = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [5:0]                    cmd_opcode,
   input  logic [1:0]                    cmd_ctrl,
   input  logic [$clog2(reg_count)-1:0]  cmd_dst,
   input  logic [$clog2(reg_count)-1:0]  cmd_src1,
   input  logic [$clog2(reg_count)-1:0]  cmd_src2,
   input  logic [$clog2(reg_count)-1:0]  cmd_src3,
   input  logic [integer_size-1:0]       cmd_int,
   output logic                          done,
   output logic [integer_size-1:0]       int_result,
   output logic                          cmp_result,
   input  logic                          ext_we,
   input  logic [$clog2(reg_count)-1:0]  ext_addr,
   input  logic [float_size-1:0]         ext_wdata,
   output logic [float_size-1:0]         ext_rdata,
   output logic                          au_enable,
   output logic [5:0]                    au_opcode,
   output logic [1:0]                    au_ctrl_flag,
   output logic [float_size-1:0]         au_flt_in1,
   output logic [float_size-1:0]         au_flt_in2,
   output logic [float_size-1:0]         au_flt_in3,
   output logic [integer_size-1:0]       au_int_in,
   input  logic [float_size-1:0]         au_flt_out,
   input  logic [integer_size-1:0]       au_int_out,
   input  logic                          au_cmp_flag,
   input  logic                          au_ready
`ifdef REFLET_FPU_SEQ_TIMEOUT_EN
   ,output logic                         timeout
`endif
);

   localparam int IDX_W = $clog2(reg_count);

   seq_state_e              state_q, state_d;
   logic [5:0]              op_q;
   logic [1:0]              ctrl_q;
   logic [IDX_W-1:0]        dst_q;
   logic [float_size-1:0]   opa_q, opb_q, opc_q, res_q;
   logic [float_size-1:0]   rd1, rd2, rd3;
   logic [integer_size-1:0] int_in_q, int_result_q;
   logic                    cmp_result_q;
   logic                    accept, wb_we, expire, aborted;
   res_class_e              cls;

   assign cls    = op_class(op_q);
   assign accept = (state_q == REFLET_SEQ_IDLE) && cmd_valid;

   reflet_float_regfile #(
      .float_size (float_size),
      .reg_count  (reg_count)
   ) u_regfile (
      .clk         (clk),
      .reset       (reset),
      .wb_we_i     (wb_we),
      .wb_addr_i   (dst_q),
      .wb_data_i   (res_q),
      .ext_we_i    (ext_we),
      .ext_addr_i  (ext_addr),
      .ext_data_i  (ext_wdata),
      .rd_addr1_i  (cmd_src1),
      .rd_addr2_i  (cmd_src2),
      .rd_addr3_i  (cmd_src3),
      .ext_raddr_i (ext_addr),
      .rd_data1_o  (rd1),
      .rd_data2_o  (rd2),
      .rd_data3_o  (rd3),
      .ext_rdata_o (ext_rdata)
   );

`ifdef REFLET_FPU_SEQ_TIMEOUT_EN
   logic [7:0] wait_cnt_q;
   logic       abort_q;

   assign expire = (wait_cnt_q == SEQ_TIMEOUT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         wait_cnt_q <= (state_q == REFLET_SEQ_EXEC) ? wait_cnt_q + 8'd1 : 8'd0;
         abort_q    <= (state_q == REFLET_SEQ_EXEC) && !au_ready && expire;
      end
   end

   assign aborted = abort_q;
   assign timeout = (state_q == REFLET_SEQ_DONE) && abort_q;
`else
   assign expire  = 1'b0;
   assign aborted = 1'b0;
`endif

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      au_enable = 1'b0;
      au_opcode = OPP_NOP;
      done      = 1'b0;
      wb_we     = 1'b0;
      case (state_q)
         REFLET_SEQ_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_d = REFLET_SEQ_EXEC;
         end
         REFLET_SEQ_EXEC: begin
            au_enable = 1'b1;
            au_opcode = op_q;
            if (au_ready)    state_d = REFLET_SEQ_WB;
            else if (expire) state_d = REFLET_SEQ_DONE;
         end
         REFLET_SEQ_WB: begin
            // Opcode stays up so the AU loads its F_TO_I/CMP registers here.
            au_enable = 1'b1;
            au_opcode = op_q;
            wb_we     = (cls == RES_FLOAT);
            state_d   = REFLET_SEQ_DONE;
         end
         REFLET_SEQ_DONE: begin
            done    = 1'b1;
            state_d = REFLET_SEQ_IDLE;
         end
         default: state_d = REFLET_SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= REFLET_SEQ_IDLE;
         op_q         <= OPP_NOP;
         ctrl_q       <= '0;
         dst_q        <= '0;
         opa_q        <= '0;
         opb_q        <= '0;
         opc_q        <= '0;
         res_q        <= '0;
         int_in_q     <= '0;
         int_result_q <= '0;
         cmp_result_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q     <= cmd_opcode;
            ctrl_q   <= cmd_ctrl;
            dst_q    <= cmd_dst;
            opa_q    <= rd1;
            opb_q    <= rd2;
            opc_q    <= rd3;
            int_in_q <= cmd_int;
         end
         if ((state_q == REFLET_SEQ_EXEC) && au_ready) res_q <= au_flt_out;
         // Integer and compare results are registered inside the AU at the WB
         // edge, so they are only valid to sample from DONE.
         if ((state_q == REFLET_SEQ_DONE) && !aborted) begin
            if (cls == RES_INT) int_result_q <= au_int_out;
            if (cls == RES_CMP) cmp_result_q <= au_cmp_flag;
         end
      end
   end

   assign au_ctrl_flag = ctrl_q;
   assign au_flt_in1   = opa_q;
   assign au_flt_in2   = opb_q;
   assign au_flt_in3   = opc_q;
   assign au_int_in    = int_in_q;
   assign int_result   = int_result_q;
   assign cmp_result   = cmp_result_q;

endmodule

// File: tb/tb_reflet_float_sequencer.sv
// Randomized bench for reflet_float_sequencer: a stub AU with programmable
// ready latency, and a register-array model of the architectural state.
`timescale 1ns/1ps
module tb_reflet_float_sequencer;
   import reflet_float_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [5:0]  cmd_opcode = '0;
   logic [1:0]  cmd_ctrl = '0;
   logic [2:0]  cmd_dst = '0, cmd_src1 = '0, cmd_src2 = '0, cmd_src3 = '0;
   logic [15:0] cmd_int = '0;
   logic        done;
   logic [15:0] int_result;
   logic        cmp_result;
   logic        ext_we = 1'b0;
   logic [2:0]  ext_addr = '0;
   logic [31:0] ext_wdata = '0;
   logic [31:0] ext_rdata;
   logic        au_enable;
   logic [5:0]  au_opcode;
   logic [1:0]  au_ctrl_flag;
   logic [31:0] au_flt_in1, au_flt_in2, au_flt_in3;
   logic [15:0] au_int_in;
   logic [31:0] au_flt_out = '0;
   logic [15:0] au_int_out = '0;
   logic        au_cmp_flag = 1'b0;
   logic        au_ready = 1'b0;
`ifdef REFLET_FPU_SEQ_TIMEOUT_EN
   logic        timeout;
`endif

   always #5 clk = ~clk;

   reflet_float_sequencer dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_ctrl(cmd_ctrl), .cmd_dst(cmd_dst), .cmd_src1(cmd_src1),
      .cmd_src2(cmd_src2), .cmd_src3(cmd_src3), .cmd_int(cmd_int),
      .done(done), .int_result(int_result), .cmp_result(cmp_result),
      .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
      .au_enable(au_enable), .au_opcode(au_opcode), .au_ctrl_flag(au_ctrl_flag),
      .au_flt_in1(au_flt_in1), .au_flt_in2(au_flt_in2), .au_flt_in3(au_flt_in3),
      .au_int_in(au_int_in), .au_flt_out(au_flt_out), .au_int_out(au_int_out),
      .au_cmp_flag(au_cmp_flag), .au_ready(au_ready)
`ifdef REFLET_FPU_SEQ_TIMEOUT_EN
      , .timeout(timeout)
`endif
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] model_regs [8];
   logic [15:0] exp_int = '0;
   logic        exp_cmp = 1'b0;

   // Stub AU: ready in the lat-th enabled cycle, float result valid only then;
   // int/cmp results appear one cycle after the cycle following ready.
   int          lat = 1;
   logic [31:0] res_flt = '0;
   logic [15:0] res_int = '0;
   logic        res_cmp = 1'b0;
   int          en_run = 0;
   logic        wb_prev = 1'b0;

   always @(negedge clk) begin
      en_run      = au_enable ? en_run + 1 : 0;
      au_ready    = au_enable && (en_run == lat);
      au_flt_out  = au_ready ? res_flt : $urandom;
      au_int_out  = wb_prev ? res_int : 16'($urandom);
      au_cmp_flag = wb_prev ? res_cmp : 1'($urandom);
      wb_prev     = au_enable && (en_run == lat + 1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_float_op(input logic [5:0] op);
      return op inside {OPP_ADD, OPP_SUB, OPP_MUL, OPP_DIV, OPP_INV, OPP_FISQRT,
                        OPP_CUBE, OPP_TESSERACT, OPP_TRIMULT, OPP_MULTADD,
                        OPP_SET_SIGN, OPP_I_TO_F};
   endfunction

   task automatic check_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         ext_addr = 3'(i);
         #1;
         check($sformatf("%s_reg%0d", tag, i), ext_rdata, model_regs[i]);
      end
   endtask

   task automatic ext_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      ext_we = 1'b1; ext_addr = a; ext_wdata = d;
      @(negedge clk);
      ext_we = 1'b0;
      model_regs[a] = d;
   endtask

   task automatic run_cmd(input logic [5:0] op, input logic [1:0] ctrl,
                          input logic [2:0] dst, input logic [2:0] s1,
                          input logic [2:0] s2, input logic [2:0] s3,
                          input logic [15:0] ival, input int l,
                          input logic [31:0] rf, input logic [15:0] ri, input logic rc,
                          input bit collide, input bit ext_mid, input bit keep_valid);
      logic [31:0] e1, e2, e3, ed;
      logic [2:0]  ea;
      bit          seen;
      @(negedge clk);
      lat = l; res_flt = rf; res_int = ri; res_cmp = rc;
      check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_opcode = op; cmd_ctrl = ctrl; cmd_dst = dst;
      cmd_src1 = s1; cmd_src2 = s2; cmd_src3 = s3; cmd_int = ival;
      e1 = model_regs[s1]; e2 = model_regs[s2]; e3 = model_regs[s3];
      ea = 3'($urandom); ed = $urandom;
      seen = 1'b0;
      for (int k = 1; k <= l + 10 && !seen; k++) begin
         @(negedge clk);
         ext_we = 1'b0;
         if (k == 1) begin
            if (keep_valid) begin
               cmd_opcode = 6'($urandom); cmd_dst = 3'($urandom);
               cmd_src1 = 3'($urandom); cmd_int = 16'($urandom);
            end else begin
               cmd_valid = 1'b0;
            end
         end
         if (done) begin
            seen = 1'b1;
            cmd_valid = 1'b0;
            check("done_latency", 32'(k), 32'(l + 2));
            check("au_enable_done", 32'(au_enable), 32'd0);
            check("au_opcode_done", 32'(au_opcode), 32'(OPP_NOP));
`ifdef REFLET_FPU_SEQ_TIMEOUT_EN
            check("timeout_normal", 32'(timeout), 32'd0);
`endif
         end else begin
            check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            check("au_enable_busy", 32'(au_enable), 32'd1);
            check("au_opcode", 32'(au_opcode), 32'(op));
            check("au_ctrl", 32'(au_ctrl_flag), 32'(ctrl));
            check("au_in1", au_flt_in1, e1);
            check("au_in2", au_flt_in2, e2);
            check("au_in3", au_flt_in3, e3);
            check("au_int_in", 32'(au_int_in), 32'(ival));
            if (k == 1 && ext_mid) begin
               ext_we = 1'b1; ext_addr = ea; ext_wdata = ed;
               model_regs[ea] = ed;
            end
            if (k == l + 1 && collide) begin
               ext_we = 1'b1; ext_addr = dst; ext_wdata = 32'hDEADBEEF;
               if (!is_float_op(op)) model_regs[dst] = 32'hDEADBEEF;
            end
         end
      end
      ext_we = 1'b0;
      check("done_seen", 32'(seen), 32'd1);
      if (is_float_op(op))      model_regs[dst] = rf;
      else if (op == OPP_F_TO_I) exp_int = ri;
      else if (op == OPP_CMP)    exp_cmp = rc;
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("int_result", 32'(int_result), 32'(exp_int));
      check("cmp_result", 32'(cmp_result), 32'(exp_cmp));
      check_regs("post");
   endtask

   task automatic reset_in_exec();
      @(negedge clk);
      lat = 50; res_flt = 32'h12345678;
      cmd_valid = 1'b1; cmd_opcode = OPP_DIV; cmd_ctrl = 2'b10; cmd_dst = 3'd6;
      cmd_src1 = 3'd1; cmd_src2 = 3'd2; cmd_src3 = 3'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("rst_exec_enable", 32'(au_enable), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_au_enable", 32'(au_enable), 32'd0);
      check("rst_au_opcode", 32'(au_opcode), 32'(OPP_NOP));
      check("rst_au_ctrl", 32'(au_ctrl_flag), 32'd0);
      for (int i = 0; i < 8; i++) begin
         model_regs[i] = '0;
      end
      exp_int = '0; exp_cmp = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check("rst_no_done", 32'(done), 32'd0);
         @(negedge clk);
      end
      check("rst_int_result", 32'(int_result), 32'(exp_int));
      check_regs("rst");
   endtask

`ifdef REFLET_FPU_SEQ_TIMEOUT_EN
   task automatic timeout_run();
      bit seen;
      @(negedge clk);
      lat = 100000; res_flt = 32'h11111111;
      cmd_valid = 1'b1; cmd_opcode = OPP_ADD; cmd_dst = 3'd5;
      cmd_src1 = 3'd1; cmd_src2 = 3'd2; cmd_src3 = 3'd3;
      seen = 1'b0;
      for (int k = 1; k <= 300 && !seen; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (done) begin
            seen = 1'b1;
            check("to_latency", 32'(k), 32'd256);
            check("to_timeout", 32'(timeout), 32'd1);
         end
      end
      check("to_done_seen", 32'(seen), 32'd1);
      @(negedge clk);
      check("to_timeout_clear", 32'(timeout), 32'd0);
      check_regs("to");
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] op;
      int         r;
      for (int i = 0; i < 8; i++) model_regs[i] = '0;
      repeat (3) @(negedge clk);
      check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset_done", 32'(done), 32'd0);
      check("reset_int_result", 32'(int_result), 32'd0);
      check("reset_cmp_result", 32'(cmp_result), 32'd0);
      check("reset_au_enable", 32'(au_enable), 32'd0);
      check("reset_au_opcode", 32'(au_opcode), 32'(OPP_NOP));
      check("reset_au_ctrl", 32'(au_ctrl_flag), 32'd0);
      reset = 1'b0;
      check_regs("reset");

      ext_write(3'd1, 32'h3F800000);
      ext_write(3'd2, 32'h40000000);
      run_cmd(OPP_ADD, 2'b00, 3'd3, 3'd1, 3'd2, 3'd0, 16'd0, 1, 32'h40400000, 16'd0, 1'b0, 0, 0, 0);
      ext_write(3'd1, 32'h3FC00000);
      run_cmd(OPP_MUL, 2'b00, 3'd0, 3'd1, 3'd2, 3'd0, 16'd0, 3, 32'h40400000, 16'd0, 1'b0, 0, 0, 1);
      run_cmd(OPP_I_TO_F, 2'b00, 3'd4, 3'd0, 3'd0, 3'd0, 16'd5, 2, 32'h40A00000, 16'd0, 1'b0, 0, 0, 0);
      run_cmd(OPP_F_TO_I, 2'b00, 3'd4, 3'd4, 3'd0, 3'd0, 16'd0, 2, 32'hCAFEF00D, 16'd5, 1'b0, 0, 0, 0);
      run_cmd(OPP_CMP, 2'b01, 3'd5, 3'd3, 3'd0, 3'd3, 16'd0, 1, 32'hCAFEF00D, 16'd0, 1'b1, 0, 0, 0);
      run_cmd(OPP_ADD, 2'b00, 3'd3, 3'd1, 3'd2, 3'd0, 16'd0, 2, 32'h40600000, 16'd0, 1'b0, 1, 0, 0);
      reset_in_exec();
`ifdef REFLET_FPU_SEQ_TIMEOUT_EN
      ext_write(3'd5, 32'h55AA55AA);
      timeout_run();
`endif

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 2) == 0) ext_write(3'($urandom), $urandom);
         r  = $urandom_range(0, 19);
         op = (r < 15) ? 6'(r) : 6'($urandom_range(15, 63));
         run_cmd(op, 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                 16'($urandom), $urandom_range(1, 4), $urandom, 16'($urandom), 1'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
